// File: rtl/bsg_async_rptr_ctrl.sv
// Read-side pointer controller for an async FIFO, living entirely in the read clock domain.
// Optional sticky protocol/consistency checker enabled by defining BSG_ASYNC_RPTR_ERR_CHECK_EN.
module bsg_async_rptr_ctrl #(
  parameter int unsigned lg_size_p = 7
) (
  input  logic                 r_clk_i,
  input  logic                 r_reset_n_i,
  input  logic [lg_size_p-1:0] w_ptr_gray_rsync_i,
  input  logic                 r_yumi_i,
  output logic                 r_valid_o,
  output logic [lg_size_p-2:0] r_addr_o,
  output logic [lg_size_p-1:0] r_ptr_binary_r_o,
  output logic [lg_size_p-1:0] r_ptr_gray_r_o,
  output logic [lg_size_p-1:0] r_count_o,
  output logic                 r_err_o
);

  localparam int unsigned Depth = 2 ** (lg_size_p - 1);
  localparam logic [lg_size_p-1:0] DepthW = lg_size_p'(Depth);

  function automatic logic [lg_size_p-1:0] gray2bin(input logic [lg_size_p-1:0] g);
    logic [lg_size_p-1:0] b;
    b[lg_size_p-1] = g[lg_size_p-1];
    for (int i = lg_size_p - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [lg_size_p-1:0] w_ptr_bin_q, w_ptr_bin_d;
  logic [lg_size_p-1:0] r_ptr_bin_q, r_ptr_bin_d;
  logic [lg_size_p-1:0] r_ptr_gray_q, r_ptr_gray_d;
  logic                 deq;

  // Occupancy and valid come only from registers, so yumi never loops back into valid.
  always_comb begin
    r_count_o        = w_ptr_bin_q - r_ptr_bin_q;
    r_valid_o        = (r_count_o != '0);
    r_addr_o         = r_ptr_bin_q[lg_size_p-2:0];
    r_ptr_binary_r_o = r_ptr_bin_q;
    r_ptr_gray_r_o   = r_ptr_gray_q;
  end

  always_comb begin
    w_ptr_bin_d  = gray2bin(w_ptr_gray_rsync_i);
    deq          = r_yumi_i & r_valid_o;
    r_ptr_bin_d  = r_ptr_bin_q;
    if (deq) begin
      r_ptr_bin_d = r_ptr_bin_q + 1'b1;
    end
    r_ptr_gray_d = r_ptr_bin_d ^ (r_ptr_bin_d >> 1);
  end

  always_ff @(posedge r_clk_i or negedge r_reset_n_i) begin
    if (!r_reset_n_i) begin
      w_ptr_bin_q  <= '0;
      r_ptr_bin_q  <= '0;
      r_ptr_gray_q <= '0;
    end else begin
      w_ptr_bin_q  <= w_ptr_bin_d;
      r_ptr_bin_q  <= r_ptr_bin_d;
      r_ptr_gray_q <= r_ptr_gray_d;
    end
  end

`ifdef BSG_ASYNC_RPTR_ERR_CHECK_EN
  logic err_q, err_d;

  // Count above depth means the synced write pointer skewed or got corrupted.
  always_comb begin
    err_d = err_q | (r_yumi_i & ~r_valid_o) | (r_count_o > DepthW);
  end

  always_ff @(posedge r_clk_i or negedge r_reset_n_i) begin
    if (!r_reset_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
`ifndef SYNTHESIS
      if (err_d && !err_q) begin
        $error("bsg_async_rptr_ctrl: protocol/consistency error (count=%0d yumi=%b)",
               r_count_o, r_yumi_i);
      end
`endif
    end
  end

  assign r_err_o = err_q;
`else
  assign r_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_async_rptr_ctrl.sv
// Scoreboard bench for bsg_async_rptr_ctrl (lg_size_p=7): each driven cycle pushes the
// expected post-edge state, which is popped and compared one edge later.
module tb_bsg_async_rptr_ctrl;

  localparam int unsigned W = 7;
  localparam int unsigned Depth = 64;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] w_gray;
  logic         yumi;
  logic         valid;
  logic [W-2:0] addr;
  logic [W-1:0] rbin;
  logic [W-1:0] rgray;
  logic [W-1:0] count;
  logic         err;

  bsg_async_rptr_ctrl #(
    .lg_size_p(W)
  ) dut (
    .r_clk_i           (clk),
    .r_reset_n_i       (rst_n),
    .w_ptr_gray_rsync_i(w_gray),
    .r_yumi_i          (yumi),
    .r_valid_o         (valid),
    .r_addr_o          (addr),
    .r_ptr_binary_r_o  (rbin),
    .r_ptr_gray_r_o    (rgray),
    .r_count_o         (count),
    .r_err_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] count;
    logic [W-2:0] addr;
    logic [W-1:0] rbin;
    logic [W-1:0] rgray;
    logic         err;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [W-1:0] m_w;
  logic [W-1:0] m_r;
  logic         m_err;

`ifdef BSG_ASYNC_RPTR_ERR_CHECK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.valid = valid;
    o.count = count;
    o.addr  = addr;
    o.rbin  = rbin;
    o.rgray = rgray;
    o.err   = err;
    return o;
  endfunction

  // Drive one cycle of stimulus and push the state expected just after the edge.
  task automatic step(input logic [W-1:0] wbin, input logic y);
    logic [W-1:0] cur_cnt;
    obs_t         e;
    cur_cnt = m_w - m_r;
    if (ErrEn) m_err = m_err | (y & (cur_cnt == 0)) | (cur_cnt > W'(Depth));
    if (y && cur_cnt != 0) m_r = m_r + 1'b1;
    m_w     = wbin;
    e.count = m_w - m_r;
    e.valid = (e.count != 0);
    e.addr  = m_r[W-2:0];
    e.rbin  = m_r;
    e.rgray = b2g(m_r);
    e.err   = m_err;
    exp_q.push_back(e);
    w_gray = b2g(wbin);
    yumi   = y;
    @(posedge clk);
    #1;
    yumi = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    w_gray = '0;
    yumi   = 1'b0;
    m_w    = '0;
    m_r    = '0;
    m_err  = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst_n  = 1'b0;
    yumi   = 1'b0;
    w_gray = 7'h55;
    repeat (2) @(posedge clk);
    #1;
    o = observed();
    n_checks++;
    if (o !== obs_t'(0)) $display("FAIL reset_hold: got %h required %h", o, obs_t'(0));
    else n_pass++;
    m_w = '0; m_r = '0; m_err = 1'b0;
    exp_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(7'd102, 1'b0);
      e = exp_q.pop_front();
      o = observed();
      n_checks++;
      if (o !== e) $display("FAIL reset_release[%0d]: got %h required %h", i, o, e);
      else n_pass++;
    end
    n_checks++;
    if (count !== 7'd102) $display("FAIL reset_release_count: got %0d required 102", count);
    else n_pass++;
  endtask

  task automatic test_write_steps();
    obs_t o, e;
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      step(W'(i), 1'b0);
      e = exp_q.pop_front();
      o = observed();
      n_checks++;
      if (o !== e) $display("FAIL write_step[%0d]: got %h required %h", i, o, e);
      else n_pass++;
      n_checks++;
      if (count !== W'(i) || valid !== 1'b1)
        $display("FAIL write_step_count[%0d]: got %0d/%b required %0d/1", i, count, valid, i);
      else n_pass++;
    end
  endtask

  task automatic test_full_drain();
    obs_t o, e;
    int   bad;
    apply_reset();
    step(7'd64, 1'b0);
    e = exp_q.pop_front();
    o = observed();
    n_checks++;
    if (o !== e || count !== 7'd64) $display("FAIL full: got %h required %h", o, e);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (addr !== 6'(i)) begin
        $display("FAIL drain_addr[%0d]: got %0d required %0d", i, addr, i);
        bad++;
      end else n_pass++;
      step(7'd64, 1'b1);
      e = exp_q.pop_front();
      o = observed();
      n_checks++;
      if (o !== e) $display("FAIL drain[%0d]: got %h required %h", i, o, e);
      else n_pass++;
    end
    n_checks++;
    if (rgray !== 7'h60 || valid !== 1'b0)
      $display("FAIL drain_end: got gray=%h valid=%b required gray=60 valid=0", rgray, valid);
    else n_pass++;
  endtask

  task automatic test_wrap();
    obs_t o, e;
    apply_reset();
    step(7'd127, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 127; i++) begin
      step(7'd127, 1'b1);
      e = exp_q.pop_front();
      o = observed();
      n_checks++;
      if (o !== e) $display("FAIL wrap_drain[%0d]: got %h required %h", i, o, e);
      else n_pass++;
    end
    step(7'd0, 1'b0);
    e = exp_q.pop_front();
    o = observed();
    n_checks++;
    if (o !== e || rgray !== 7'h40 || count !== 7'd1)
      $display("FAIL wrap_pre: got %h required %h", o, e);
    else n_pass++;
    step(7'd0, 1'b1);
    e = exp_q.pop_front();
    o = observed();
    n_checks++;
    if (o !== e || rbin !== 7'd0 || rgray !== 7'h00 || count !== 7'd0)
      $display("FAIL wrap_post: got %h required %h", o, e);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    obs_t o, e;
    apply_reset();
    step(7'd5, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 6; i < 10; i++) begin
      step(W'(i), 1'b1);
      e = exp_q.pop_front();
      o = observed();
      n_checks++;
      if (o !== e || count !== 7'd5) $display("FAIL simult[%0d]: got %h required %h", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    obs_t         o, e;
    logic [W-1:0] nw;
    int           cnt, adv;
    logic         y;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      cnt = int'(W'(m_w - m_r));
      y   = (cnt != 0) && ($urandom_range(0, 2) != 0);
      adv = $urandom_range(0, 2);
      if (cnt - int'(y) + adv > int'(Depth)) adv = 0;
      nw = m_w + W'(adv);
      step(nw, y);
      e = exp_q.pop_front();
      o = observed();
      n_checks++;
      if (o !== e) $display("FAIL random[%0d]: got %h required %h", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      step(7'd0, 1'b1);
      e = exp_q.pop_front();
      o = observed();
      n_checks++;
      if (o !== e || rbin !== 7'd0 || err !== ErrEn)
        $display("FAIL underflow[%0d]: got %h required %h", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    apply_reset();
    step(7'd10, 1'b0);
    void'(exp_q.pop_front());
    repeat (3) begin
      step(7'd10, 1'b1);
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (rbin !== 7'd3 || count !== 7'd7)
      $display("FAIL pre_async_reset: got rbin=%0d count=%0d required 3/7", rbin, count);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    o = observed();
    n_checks++;
    if (o !== obs_t'(0)) $display("FAIL async_reset: got %h required %h", o, obs_t'(0));
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    w_gray = '0;
    yumi   = 1'b0;
    m_w    = '0;
    m_r    = '0;
    m_err  = 1'b0;
    test_reset();
    test_write_steps();
    test_full_drain();
    test_wrap();
    test_simultaneous();
    test_random();
    test_underflow();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
